// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared pipeline-geometry helpers for the pipelined array
//               multiplier (stage count and end-to-end latency).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Number of carry-save reduction stages for N rows packed ROWS per stage.
    function automatic int calc_stages(input int n, input int rows);
        return (n + rows - 1) / rows;
    endfunction

    // Accept-edge to out_valid latency: operand capture + stages + final add.
    function automatic int calc_latency(input int n, input int rows);
        return calc_stages(n, rows) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_array_multiplier_csa_row.sv
`default_nettype none
// ============================================================================
// Module      : csa_row
// Description : One carry-save row of the array multiplier. Adds the partial
//               product a & x_j (weight 2^J) into a full-width sum/carry pair
//               using M full-adder cells. Baugh-Wooley sign correction is
//               applied by inverting selected partial-product bits.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_row #(
    parameter int M = 16,
    parameter int N = 16,
    parameter int J = 0
) (
    input  logic [M+N-1:0] sum_i,
    input  logic [M+N-1:0] carry_i,
    input  logic [M-1:0]   a_i,
    input  logic           x_i,
    input  logic           inv_msb_i,   // invert a[M-1]&x_j (rows j < N-1, signed)
    input  logic           inv_low_i,   // invert a[M-2:0]&x_j (row N-1, signed)
    output logic [M+N-1:0] sum_o,
    output logic [M+N-1:0] carry_o
);

    logic [M-1:0] w_pp;
    logic [M-1:0] w_fa_sum;
    logic [M-1:0] w_fa_carry;

    assign w_pp[M-1]   = (a_i[M-1] & x_i) ^ inv_msb_i;
    assign w_pp[M-2:0] = (a_i[M-2:0] & {(M-1){x_i}}) ^ {(M-1){inv_low_i}};

    // One full adder per multiplicand bit, aligned at bit position J+i.
    for (genvar i = 0; i < M; i++) begin : g_cell
        assign w_fa_sum[i]   = sum_i[J+i] ^ carry_i[J+i] ^ w_pp[i];
        assign w_fa_carry[i] = (sum_i[J+i] & carry_i[J+i])
                             | (sum_i[J+i] & w_pp[i])
                             | (carry_i[J+i] & w_pp[i]);
    end

    // Bits outside the window pass through. Earlier rows only leave carries at
    // or below position J+M-1, so the carry slots J+1..J+M are free to rewrite.
    always_comb begin
        sum_o                = sum_i;
        carry_o              = carry_i;
        sum_o[J+M-1:J]       = w_fa_sum;
        carry_o[J+M:J+1]     = w_fa_carry;
        carry_o[J]           = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_array_multiplier
// Description : M x N array multiplier, unsigned or two's complement (tc),
//               carry-save reduced ROWS rows per stage, final carry-propagate
//               add, valid/ready handshake with a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier
    import mult_pkg::*;
#(
    parameter int M    = 16,
    parameter int N    = 16,
    parameter int ROWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     x,
    input  logic             tc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   product
);

    localparam int          c_p   = calc_stages(N, ROWS);
    localparam int          c_w   = M + N;
    localparam logic [c_w-1:0] c_one = c_w'(1);
    // Baugh-Wooley correction constant: 2^(M-1) + 2^(N-1) + 2^(M+N-1).
    localparam logic [c_w-1:0] c_bw_const = (c_one << (M-1)) + (c_one << (N-1))
                                          + (c_one << (c_w-1));

    // Register index s feeds reduction stage s; index c_p feeds the final add.
    logic [M-1:0]   st_a_q     [0:c_p-1];
    logic [N-1:0]   st_x_q     [0:c_p-1];
    logic           st_tc_q    [0:c_p-1];
    logic [c_w-1:0] st_sum_q   [1:c_p];
    logic [c_w-1:0] st_carry_q [1:c_p];
    logic [c_p:0]   st_valid_q;
    logic           out_valid_q;
    logic [c_w-1:0] product_q;

    logic [c_w-1:0] w_in_sum    [0:N-1];
    logic [c_w-1:0] w_in_carry  [0:N-1];
    logic [c_w-1:0] w_row_sum   [0:N-1];
    logic [c_w-1:0] w_row_carry [0:N-1];
    logic           w_advance;

    assign w_advance = !out_valid_q || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = out_valid_q;
    assign product   = product_q;

    for (genvar j = 0; j < N; j++) begin : g_row
        localparam int c_s = j / ROWS;
        if (j == 0) begin : g_first
            assign w_in_sum[j]   = st_tc_q[0] ? c_bw_const : '0;
            assign w_in_carry[j] = '0;
        end else if (j % ROWS == 0) begin : g_stage_entry
            assign w_in_sum[j]   = st_sum_q[c_s];
            assign w_in_carry[j] = st_carry_q[c_s];
        end else begin : g_chain
            assign w_in_sum[j]   = w_row_sum[j-1];
            assign w_in_carry[j] = w_row_carry[j-1];
        end

        csa_row #(
            .M (M),
            .N (N),
            .J (j)
        ) u_row (
            .sum_i     (w_in_sum[j]),
            .carry_i   (w_in_carry[j]),
            .a_i       (st_a_q[c_s]),
            .x_i       (st_x_q[c_s][j]),
            .inv_msb_i (st_tc_q[c_s] && (j != N-1)),
            .inv_low_i (st_tc_q[c_s] && (j == N-1)),
            .sum_o     (w_row_sum[j]),
            .carry_o   (w_row_carry[j])
        );
    end

    for (genvar s = 0; s < c_p; s++) begin : g_stage
        localparam int c_last = (((s + 1) * ROWS < N) ? (s + 1) * ROWS : N) - 1;

        // Capture this stage's carry-save result for the next stage.
        always_ff @(posedge clk) begin
            if (w_advance) begin
                st_sum_q[s+1]   <= w_row_sum[c_last];
                st_carry_q[s+1] <= w_row_carry[c_last];
            end
        end

        if (s == 0) begin : g_capture
            // Operand capture; valid bits alone qualify these registers.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    st_a_q[0]  <= a;
                    st_x_q[0]  <= x;
                    st_tc_q[0] <= tc;
                end
            end
        end else begin : g_forward
            // Operands and mode travel alongside their partial sums.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    st_a_q[s]  <= st_a_q[s-1];
                    st_x_q[s]  <= st_x_q[s-1];
                    st_tc_q[s] <= st_tc_q[s-1];
                end
            end
        end
    end

    // Valid pipeline and final carry-propagate add, all frozen on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_q  <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (w_advance) begin
            st_valid_q  <= {st_valid_q[c_p-1:0], in_valid};
            out_valid_q <= st_valid_q[c_p];
            if (st_valid_q[c_p]) begin
                product_q <= st_sum_q[c_p] + st_carry_q[c_p];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipelined_array_multiplier.md
PIPELINED_ARRAY_MULTIPLIER -- requirements
Module: pipelined_array_multiplier

Interface
REQ-001 SHALL have parameter M, default 16, multiplicand (a) width, M >= 2.
REQ-002 SHALL have parameter N, default 16, multiplier (x) width, N >= 2.
REQ-003 SHALL have parameter ROWS, default 4, partial-product rows per pipeline stage, 1 <= ROWS <= N.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand set present on a, x, tc.
REQ-007 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port a  input  M  multiplicand.
REQ-009 SHALL have port x  input  N  multiplier.
REQ-010 SHALL have port tc  input  1  1 = both operands two's complement, 0 = both unsigned.
REQ-011 SHALL have port out_valid  output  1  product holds a valid result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts product this cycle.
REQ-013 SHALL have port product  output  M+N  result.

Function
REQ-014 SHALL, for tc=0, produce product = a*x, unsigned, exact in M+N bits.
REQ-015 SHALL, for tc=1, produce product = a*x, signed, exact in M+N bits (Baugh-Wooley sign correction, no operand pre-negation).
REQ-016 SHALL reduce the N partial-product rows carry-save, with ROWS rows per stage; stage count P = ceil(N/ROWS).
REQ-017 SHALL register the carry-save pair and tc after each of the P stages, then perform a final carry-propagate add registered into product.
REQ-018 SHALL have latency L = P+1: operands accepted at edge k appear with out_valid=1 after edge k+L, provided no stall occurs.
REQ-019 SHALL accept operands at an edge only when in_valid=1 and in_ready=1; tc travels with its operands, so mixed modes stream back to back.
REQ-020 SHALL sustain one result per cycle when out_ready=1 continuously.
REQ-021 SHALL define advance = !out_valid || out_ready, and SHALL drive in_ready = advance combinationally.
REQ-022 SHALL, when advance=0, hold every pipeline register, valid bit and product unchanged (global stall), with no loss or duplication of results.
REQ-023 SHALL carry a valid bit per stage; empty slots (bubbles) SHALL NOT raise out_valid.
REQ-024 SHALL complete a transfer when out_valid=1 and out_ready=1; product SHALL then change only to the next valid result or go invalid.
REQ-025 SHALL keep product stable while out_valid=1 and out_ready=0.
REQ-026 SHALL NOT require out_ready=1 before out_valid=1, and SHALL NOT combinationally feed in_valid into out_valid.
REQ-027 SHALL, when ROWS=N (P=1), behave with L=2 and still meet REQ-018 to REQ-025.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, clear all stage valid bits and out_valid to 0 and product to 0.
REQ-029 SHALL discard all in-flight operations on mid-operation reset; no result from before reset SHALL ever appear.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset deassertion (pipeline empty).
REQ-031 SHALL NOT require reset of datapath registers other than product; valid bits alone qualify them.

Structure
REQ-032 SHALL place the stage-count and latency functions (P, L from N, ROWS) in shared package mult_pkg, for use by the RTL and the bench.
REQ-033 SHALL implement one carry-save row as sub-module csa_row (M full-adder cells, sign-correction controls as inputs), instantiated N times via generate.
REQ-034 SHALL use only the single clock clk; no latches, no gated clocks.

Verification (M=N=16, ROWS=4, so P=4, L=5)
REQ-035 SHALL check a=0xFFFF, x=0xFFFF, tc=0 -> product 0xFFFE0001, out_valid high exactly 5 cycles after accept.
REQ-036 SHALL check tc=1 cases a=0x8000,x=0x8000 -> 0x40000000; a=0xFFFF,x=0x0001 -> 0xFFFFFFFF; a=0x7FFF,x=0x8000 -> 0xC0008000.
REQ-037 SHALL check a 100-operation random stream with alternating tc, out_ready=1 -> one correct result per cycle, in order.
REQ-038 SHALL check out_ready held 0 for 10 cycles with a full pipeline -> in_ready=0, product frozen; on release, all results delivered in order without loss.
REQ-039 SHALL check rst pulsed for 1 cycle with 3 operations in flight -> out_valid=0 and product=0 next cycle; none of the 3 results ever appears.
REQ-040 SHALL check ROWS=16 (L=2) and ROWS=1 (L=17) builds with 1000 random operands each, both tc values -> exact match with a reference model.
